// File: rtl/ahb3lite_mem_arbiter_if.sv
// ahb3lite_mem_arbiter_if
//   Bus bundle between two slave-side requesters, the arbiter and the
//   single-port memory.
//   Requester side : req_i, we_i, lock_i, addr_i, wdata_i  -> arbiter
//                    grant_o, ack_o, rvalid_o, err_o, rdata_o <- arbiter
//   Memory side    : READ_addr, read_flag, WRITE_addr, write_flag, HWDATA -> memory
//                    HRDATA <- memory (combinational read data)
//   Modports: slave  = arbiter view
//             master = requester/memory environment view
interface ahb3lite_mem_arbiter_if;
  logic [1:0]       req_i;
  logic [1:0]       we_i;
  logic [1:0]       lock_i;
  logic [1:0][31:0] addr_i;
  logic [1:0][31:0] wdata_i;
  logic [1:0]       grant_o;
  logic [1:0]       ack_o;
  logic [1:0]       rvalid_o;
  logic [1:0]       err_o;
  logic [31:0]      rdata_o;
  logic [31:0]      READ_addr;
  logic             read_flag;
  logic [31:0]      HRDATA;
  logic [31:0]      WRITE_addr;
  logic             write_flag;
  logic [31:0]      HWDATA;

  modport slave (
    input  req_i, we_i, lock_i, addr_i, wdata_i, HRDATA,
    output grant_o, ack_o, rvalid_o, err_o, rdata_o,
           READ_addr, read_flag, WRITE_addr, write_flag, HWDATA
  );

  modport master (
    output req_i, we_i, lock_i, addr_i, wdata_i, HRDATA,
    input  grant_o, ack_o, rvalid_o, err_o, rdata_o,
           READ_addr, read_flag, WRITE_addr, write_flag, HWDATA
  );
endinterface

// File: rtl/ahb3lite_mem_arbiter.sv
// ahb3lite_mem_arbiter
//   Round-robin arbiter sharing one single-port memory between two
//   requesters, with a bounded lock so an owner can keep the memory for up
//   to MAX_BURST consecutive granted cycles. One memory access per cycle;
//   read data and completion pulses come back registered one cycle later.
//
//   Parameters: DEPTH     memory depth in 32-bit words (power of two)
//               MAX_BURST max granted cycles per locked tenure (1..15)
//   Ports:      HCLK      clock, rising edge
//               HRESET    synchronous active-high reset
//               bus       ahb3lite_mem_arbiter_if.slave (requester + memory side)
//
//   Optional feature: define MEM_ARB_ADDR_CHECK_EN to reject beats whose
//   address is >= DEPTH (acked, memory untouched, err_o pulse). Without it
//   the address wraps modulo DEPTH and err_o is tied to 0.
//
//   Grant state (grant_q):
//     state | meaning
//     00    | idle, no owner
//     01    | requester 0 owns the memory
//     10    | requester 1 owns the memory
module ahb3lite_mem_arbiter #(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned MAX_BURST = 4
) (
  input logic                  HCLK,
  input logic                  HRESET,
  ahb3lite_mem_arbiter_if.slave bus
);

  localparam logic [31:0] ADDR_MASK = 32'(DEPTH - 1);
  localparam logic [4:0]  BURST_LIM = 5'(MAX_BURST);

  logic [1:0]  grant_q, grant_d;
  logic        last_owner_q, last_owner_d;
  logic [3:0]  tenure_q, tenure_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        owner;
  logic [1:0]  ack;
  logic        acc;
  logic        owner_we;
  logic [31:0] owner_addr;
  logic [31:0] eff_addr;
  logic        addr_ok;
  logic        mem_en;
  logic        keep;

  // grant_q is one-hot, so bit 1 alone identifies the owner when granted.
  assign owner = grant_q[1];

  always_comb begin
    ack        = grant_q & bus.req_i;
    acc        = |ack;
    owner_we   = bus.we_i[owner];
    owner_addr = bus.addr_i[owner];
    eff_addr   = owner_addr & ADDR_MASK;
`ifdef MEM_ARB_ADDR_CHECK_EN
    addr_ok    = (owner_addr < 32'(DEPTH));
`else
    addr_ok    = 1'b1;
`endif
    // Memory is only touched by an accepted, in-range beat outside reset.
    mem_en     = acc & addr_ok & ~HRESET;
  end

  assign bus.ack_o      = ack;
  assign bus.read_flag  = mem_en & ~owner_we;
  assign bus.write_flag = mem_en & owner_we;
  assign bus.READ_addr  = mem_en ? eff_addr : 32'd0;
  assign bus.WRITE_addr = mem_en ? eff_addr : 32'd0;
  assign bus.HWDATA     = mem_en ? bus.wdata_i[owner] : 32'd0;

  assign bus.grant_o    = grant_q;
  assign bus.rvalid_o   = rvalid_q;
  assign bus.err_o      = err_q;
  assign bus.rdata_o    = rdata_q;

  always_comb begin
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    tenure_d     = tenure_q;

    // A locked owner keeps the grant even with req low, until the tenure
    // bound is reached.
    keep = (|grant_q) & bus.lock_i[owner] &
           (({1'b0, tenure_q} + 5'd1) < BURST_LIM);

    if (keep) begin
      tenure_d = tenure_q + 4'd1;
    end else begin
      tenure_d = 4'd0;
      case (bus.req_i)
        2'b11: begin
          grant_d      = last_owner_q ? 2'b01 : 2'b10;
          last_owner_d = ~last_owner_q;
        end
        2'b01: begin
          grant_d      = 2'b01;
          last_owner_d = 1'b0;
        end
        2'b10: begin
          grant_d      = 2'b10;
          last_owner_d = 1'b1;
        end
        default: grant_d = 2'b00;
      endcase
    end

    rvalid_d = ack & ~bus.we_i & {2{addr_ok}};
`ifdef MEM_ARB_ADDR_CHECK_EN
    err_d    = ack & {2{~addr_ok}};
`else
    err_d    = 2'b00;
`endif
    rdata_d  = (mem_en & ~owner_we) ? bus.HRDATA : rdata_q;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_q      <= 2'b00;
      last_owner_q <= 1'b1;
      tenure_q     <= 4'd0;
      rvalid_q     <= 2'b00;
      err_q        <= 2'b00;
      rdata_q      <= 32'd0;
    end else begin
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      tenure_q     <= tenure_d;
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ahb3lite_mem_arbiter.sv
module tb_ahb3lite_mem_arbiter;
  localparam int DEPTH     = 4096;
  localparam int MAX_BURST = 4;
  localparam int AW        = 12;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  ahb3lite_mem_arbiter_if bus();

  ahb3lite_mem_arbiter #(.DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  // Memory model with a backdoor port for preloading.
  logic [31:0]   mem [DEPTH];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_data;
  assign bus.HRDATA = mem[bus.READ_addr[AW-1:0]];
  always @(posedge HCLK) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (bus.write_flag) mem[bus.WRITE_addr[AW-1:0]] <= bus.HWDATA;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_i   = 2'b00;
    bus.we_i    = 2'b00;
    bus.lock_i  = 2'b00;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    idle_inputs();
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [31:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    tick();
    bd_we   = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    idle_inputs();
    bus.req_i = 2'b11;
    tick();
    #1;
    n_checks++; if (bus.grant_o !== 2'b00) $display("FAIL rst_grant got %b exp 00", bus.grant_o); else n_pass++;
    n_checks++; if (bus.rvalid_o !== 2'b00) $display("FAIL rst_rvalid got %b exp 00", bus.rvalid_o); else n_pass++;
    n_checks++; if (bus.err_o !== 2'b00) $display("FAIL rst_err got %b exp 00", bus.err_o); else n_pass++;
    n_checks++; if (bus.rdata_o !== 32'd0) $display("FAIL rst_rdata got %h exp 0", bus.rdata_o); else n_pass++;
    n_checks++; if ({bus.read_flag, bus.write_flag} !== 2'b00) $display("FAIL rst_flags got %b exp 00", {bus.read_flag, bus.write_flag}); else n_pass++;
    idle_inputs();
    HRESET = 1'b0;
  endtask

  task automatic test_write_read();
    do_reset();
    bus.req_i[0] = 1'b1; bus.we_i[0] = 1'b1;
    bus.addr_i[0] = 32'd5; bus.wdata_i[0] = 32'hDEADBEEF;
    #1;
    n_checks++; if (bus.ack_o !== 2'b00) $display("FAIL wr_early_ack got %b exp 00", bus.ack_o); else n_pass++;
    tick();
    n_checks++; if (bus.grant_o !== 2'b01) $display("FAIL wr_grant got %b exp 01", bus.grant_o); else n_pass++;
    n_checks++; if (bus.ack_o !== 2'b01) $display("FAIL wr_ack got %b exp 01", bus.ack_o); else n_pass++;
    n_checks++; if (bus.write_flag !== 1'b1 || bus.read_flag !== 1'b0) $display("FAIL wr_flags got w%b r%b exp w1 r0", bus.write_flag, bus.read_flag); else n_pass++;
    n_checks++; if (bus.WRITE_addr !== 32'd5 || bus.HWDATA !== 32'hDEADBEEF) $display("FAIL wr_port got %h/%h exp 5/deadbeef", bus.WRITE_addr, bus.HWDATA); else n_pass++;
    tick();
    n_checks++; if (bus.rvalid_o !== 2'b00) $display("FAIL wr_no_rvalid got %b exp 00", bus.rvalid_o); else n_pass++;
    bus.we_i[0] = 1'b0;
    #1;
    n_checks++; if (bus.read_flag !== 1'b1 || bus.READ_addr !== 32'd5) $display("FAIL rd_port got r%b a%h exp r1 a5", bus.read_flag, bus.READ_addr); else n_pass++;
    tick();
    bus.req_i = 2'b00;
    n_checks++; if (bus.rvalid_o !== 2'b01) $display("FAIL rd_rvalid got %b exp 01", bus.rvalid_o); else n_pass++;
    n_checks++; if (bus.rdata_o !== 32'hDEADBEEF) $display("FAIL rd_rdata got %h exp deadbeef", bus.rdata_o); else n_pass++;
    tick();
    n_checks++; if (bus.rvalid_o !== 2'b00) $display("FAIL rd_pulse_width got %b exp 00", bus.rvalid_o); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    logic [1:0] prev_g;
    int acks0, acks1;
    do_reset();
    bus.req_i = 2'b11;
    acks0 = 0; acks1 = 0; prev_g = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++; if (bus.grant_o !== exp_g) $display("FAIL cont_grant%0d got %b exp %b", k, bus.grant_o, exp_g); else n_pass++;
      n_checks++; if (bus.rvalid_o !== prev_g) $display("FAIL cont_rvalid%0d got %b exp %b", k, bus.rvalid_o, prev_g); else n_pass++;
      if (bus.ack_o[0] === 1'b1) acks0++;
      if (bus.ack_o[1] === 1'b1) acks1++;
      prev_g = exp_g;
    end
    n_checks++; if (acks0 != 2 || acks1 != 2) $display("FAIL cont_acks got %0d/%0d exp 2/2", acks0, acks1); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_lock_bound();
    do_reset();
    bus.req_i = 2'b11; bus.lock_i = 2'b01;
    for (int k = 0; k < MAX_BURST; k++) begin
      tick();
      n_checks++; if (bus.grant_o !== 2'b01) $display("FAIL lock_grant%0d got %b exp 01", k, bus.grant_o); else n_pass++;
    end
    tick();
    n_checks++; if (bus.grant_o !== 2'b10) $display("FAIL lock_switch got %b exp 10", bus.grant_o); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_addr_check();
    do_reset();
    bd_write(12'd0, 32'h0BADF00D);
    bus.req_i[0] = 1'b1; bus.we_i[0] = 1'b1;
    bus.addr_i[0] = 32'h1000; bus.wdata_i[0] = 32'h12345678;
    tick();
    n_checks++; if (bus.ack_o !== 2'b01) $display("FAIL ac_ack got %b exp 01", bus.ack_o); else n_pass++;
`ifdef MEM_ARB_ADDR_CHECK_EN
    n_checks++; if (bus.write_flag !== 1'b0) $display("FAIL ac_wflag got %b exp 0", bus.write_flag); else n_pass++;
`else
    n_checks++; if (bus.write_flag !== 1'b1 || bus.WRITE_addr !== 32'd0) $display("FAIL ac_wrap got w%b a%h exp w1 a0", bus.write_flag, bus.WRITE_addr); else n_pass++;
`endif
    tick();
`ifdef MEM_ARB_ADDR_CHECK_EN
    n_checks++; if (bus.err_o !== 2'b01) $display("FAIL ac_err got %b exp 01", bus.err_o); else n_pass++;
`else
    n_checks++; if (bus.err_o !== 2'b00) $display("FAIL ac_err got %b exp 00", bus.err_o); else n_pass++;
`endif
    n_checks++; if (bus.rvalid_o !== 2'b00) $display("FAIL ac_rvalid got %b exp 00", bus.rvalid_o); else n_pass++;
    bus.we_i[0] = 1'b0; bus.addr_i[0] = 32'd0;
    tick();
    bus.req_i = 2'b00;
    n_checks++; if (bus.err_o !== 2'b00) $display("FAIL ac_err_width got %b exp 00", bus.err_o); else n_pass++;
`ifdef MEM_ARB_ADDR_CHECK_EN
    n_checks++; if (bus.rvalid_o !== 2'b01 || bus.rdata_o !== 32'h0BADF00D) $display("FAIL ac_readback got %b/%h exp 01/0badf00d", bus.rvalid_o, bus.rdata_o); else n_pass++;
`else
    n_checks++; if (bus.rvalid_o !== 2'b01 || bus.rdata_o !== 32'h12345678) $display("FAIL ac_readback got %b/%h exp 01/12345678", bus.rvalid_o, bus.rdata_o); else n_pass++;
`endif
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bd_write(12'd7, 32'hCAFE0007);
    bus.req_i = 2'b10; bus.lock_i = 2'b10; bus.addr_i[1] = 32'd7;
    tick();
    n_checks++; if (bus.grant_o !== 2'b10) $display("FAIL rmb_grant got %b exp 10", bus.grant_o); else n_pass++;
    tick();
    n_checks++; if (bus.rvalid_o !== 2'b10 || bus.rdata_o !== 32'hCAFE0007) $display("FAIL rmb_rd got %b/%h exp 10/cafe0007", bus.rvalid_o, bus.rdata_o); else n_pass++;
    HRESET = 1'b1;
    #1;
    n_checks++; if ({bus.read_flag, bus.write_flag} !== 2'b00) $display("FAIL rmb_flags_in_rst got %b exp 00", {bus.read_flag, bus.write_flag}); else n_pass++;
    tick();
    n_checks++; if ({bus.grant_o, bus.rvalid_o, bus.err_o, bus.ack_o} !== 8'd0) $display("FAIL rmb_ctrl got %b exp 0", {bus.grant_o, bus.rvalid_o, bus.err_o, bus.ack_o}); else n_pass++;
    n_checks++; if (bus.rdata_o !== 32'd0) $display("FAIL rmb_rdata got %h exp 0", bus.rdata_o); else n_pass++;
    HRESET = 1'b0;
    idle_inputs();
    bus.req_i = 2'b01;
    tick();
    n_checks++; if (bus.grant_o !== 2'b01) $display("FAIL rmb_regrant got %b exp 01", bus.grant_o); else n_pass++;
    n_checks++; if (bus.rvalid_o !== 2'b00) $display("FAIL rmb_no_rvalid got %b exp 00", bus.rvalid_o); else n_pass++;
    idle_inputs();
    tick();
  endtask

  // Randomized traffic checked against a cycle-level reference: owner index,
  // round-robin pointer and tenure as integers, expected memory as an array.
  task automatic test_random();
    logic [31:0] ref_mem [16];
    bit          pend [2];
    logic        p_we [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata [2];
    int          m_owner, m_last, m_ten, winner, o, eff;
    logic [1:0]  m_grant, exp_rvalid, exp_err, exp_ack;
    logic [31:0] exp_rdata;
    logic        in_range, exp_rf, exp_wf;

    do_reset();
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = $urandom;
      bd_write(AW'(a), ref_mem[a]);
    end
    m_owner = -1; m_last = 1; m_ten = 0;
    exp_rvalid = 2'b00; exp_err = 2'b00; exp_rdata = 32'd0;
    pend[0] = 0; pend[1] = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      m_grant = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
      n_checks++; if (bus.grant_o !== m_grant) $display("FAIL rnd_grant c%0d got %b exp %b", cyc, bus.grant_o, m_grant); else n_pass++;
      n_checks++; if (bus.rvalid_o !== exp_rvalid) $display("FAIL rnd_rvalid c%0d got %b exp %b", cyc, bus.rvalid_o, exp_rvalid); else n_pass++;
      n_checks++; if (bus.err_o !== exp_err) $display("FAIL rnd_err c%0d got %b exp %b", cyc, bus.err_o, exp_err); else n_pass++;
      if (exp_rvalid != 2'b00) begin
        n_checks++; if (bus.rdata_o !== exp_rdata) $display("FAIL rnd_rdata c%0d got %h exp %h", cyc, bus.rdata_o, exp_rdata); else n_pass++;
      end

      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) != 0) begin
          pend[r]    = 1;
          p_we[r]    = 1'($urandom_range(0, 1));
          p_addr[r]  = 32'($urandom_range(0, 15));
          if ($urandom_range(0, 3) == 0) p_addr[r] = p_addr[r] + 32'h1000 * 32'($urandom_range(1, 7));
          p_wdata[r] = $urandom;
        end
        bus.req_i[r]   = pend[r];
        bus.we_i[r]    = pend[r] ? p_we[r] : 1'b0;
        bus.addr_i[r]  = pend[r] ? p_addr[r] : 32'd0;
        bus.wdata_i[r] = pend[r] ? p_wdata[r] : 32'd0;
        bus.lock_i[r]  = ($urandom_range(0, 2) != 0);
      end
      #1;

      exp_ack = m_grant & bus.req_i;
      n_checks++; if (bus.ack_o !== exp_ack) $display("FAIL rnd_ack c%0d got %b exp %b", cyc, bus.ack_o, exp_ack); else n_pass++;

      exp_rvalid = 2'b00; exp_err = 2'b00; exp_rf = 0; exp_wf = 0;
      if (exp_ack != 2'b00) begin
        o   = m_owner;
        eff = int'(p_addr[o] % DEPTH);
`ifdef MEM_ARB_ADDR_CHECK_EN
        in_range = (p_addr[o] < DEPTH);
`else
        in_range = 1'b1;
`endif
        exp_rf = in_range & ~p_we[o];
        exp_wf = in_range & p_we[o];
        if (!in_range) exp_err[o] = 1'b1;
        else if (!p_we[o]) begin
          exp_rvalid[o] = 1'b1;
          exp_rdata     = ref_mem[eff % 16];
        end
        pend[o] = 0;
      end
      n_checks++; if ({bus.read_flag, bus.write_flag} !== {exp_rf, exp_wf}) $display("FAIL rnd_flags c%0d got %b exp %b", cyc, {bus.read_flag, bus.write_flag}, {exp_rf, exp_wf}); else n_pass++;
      if (exp_rf) begin
        n_checks++; if (bus.READ_addr !== 32'(eff)) $display("FAIL rnd_raddr c%0d got %h exp %h", cyc, bus.READ_addr, eff); else n_pass++;
      end
      if (exp_wf) begin
        n_checks++; if (bus.WRITE_addr !== 32'(eff) || bus.HWDATA !== p_wdata[o]) $display("FAIL rnd_wport c%0d got %h/%h exp %h/%h", cyc, bus.WRITE_addr, bus.HWDATA, eff, p_wdata[o]); else n_pass++;
        ref_mem[eff % 16] = p_wdata[o];
      end

      if (m_owner >= 0 && bus.lock_i[m_owner] && m_ten + 1 < MAX_BURST) begin
        m_ten++;
      end else begin
        m_ten = 0;
        if (bus.req_i == 2'b11) winner = 1 - m_last;
        else if (bus.req_i[0]) winner = 0;
        else if (bus.req_i[1]) winner = 1;
        else winner = -1;
        if (winner >= 0) m_last = winner;
        m_owner = winner;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    HRESET = 1'b1;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_contention();
    test_lock_bound();
    test_addr_check();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
